fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
Parametrised FFT stage/address sequencer; next generation of the fixed 4-lane point-configuration controller.
Sequences all log2(N) radix-2 stages for run-time N = 2^i_log2n with LANES butterflies issued per cycle.
Per stage it issues the butterfly indices, drains the datapath writeback pipeline, and flips the ping-pong SRAM bank.
Sits between the top-level start/done handshake and the butterfly datapath, twiddle ROM and SRAM address generators.

Parameters:
MAX_LOG2N, 10, largest supported log2(points); sets all index widths.
LANES, 4, butterflies issued per cycle; power of two, 1..2^(MAX_LOG2N-1).
PIPE_DELAY, 5, cycles from issue to datapath writeback; must be at least 1.

Ports:
clk  in  1  clock
i_resetn  in  1  reset
i_start  in  1  start request; sampled only in IDLE
i_log2n  in  $clog2(MAX_LOG2N+1)  log2(points); latched at start
i_stall  in  1  hold issue this cycle
o_busy  out  1  high from start acceptance until o_done
o_cfg_err  out  1  one-cycle pulse when start is rejected
o_stage_start  out  1  one-cycle pulse in the first ISSUE cycle of each stage
o_stage_idx  out  $clog2(MAX_LOG2N)  current stage index s
o_issue_valid  out  1  o_calc_idx is valid this cycle
o_calc_idx  out  MAX_LOG2N-1  index of the first butterfly in the issued group
o_stride  out  MAX_LOG2N  N >> (s+1)
o_stride_idx_offset  out  MAX_LOG2N  o_stride >> log2(LANES); 0 when o_stride < LANES
o_group_count  out  MAX_LOG2N  1 << s
o_bank_sel  out  1  read bank; write bank is its inverse
o_wb_valid  out  1  o_issue_valid delayed by PIPE_DELAY
o_wb_idx  out  MAX_LOG2N-1  o_calc_idx delayed by PIPE_DELAY
o_done  out  1  one-cycle completion pulse
o_cycle_count  out  16  see Optional Feature

Behaviour:
- Reset: i_resetn, asynchronous, active-low; clock clk. While reset is asserted, all outputs are 0, the FSM is in IDLE and the delay lines are cleared. Reset mid-run aborts the run immediately; there is no completion pulse.
- States:
  - IDLE. On i_start, if i_log2n is in the range 2..MAX_LOG2N: latch N, set s=0, counter=0, bank=0, go to ISSUE. Otherwise pulse o_cfg_err and stay in IDLE.
  - ISSUE. Each cycle with i_stall=0: o_issue_valid=1, o_calc_idx=counter, counter += LANES. After the issue where counter+LANES >= N/2, go to DRAIN. A stalled cycle holds the counter and drives o_issue_valid=0.
  - DRAIN. Wait exactly PIPE_DELAY cycles; i_stall is ignored here. Then:
    - if s == log2N-1, go to DONE;
    - else s++, counter=0, bank toggles, go to ISSUE.
  - DONE. Pulse o_done for one cycle, drop o_busy, return to IDLE.
- Issue cycles per stage = max(1, N/(2*LANES)). When LANES > N/2, one issue cycle covers the stage; lanes beyond N/2 are the datapath's to mask.
- Counter width is MAX_LOG2N bits, so counter+LANES never wraps.
- o_stage_start is asserted on the first ISSUE cycle of a stage even if that cycle is stalled.
- Writeback: o_wb_valid and o_wb_idx always reflect the delay line, including during DRAIN. The last writeback of a stage lands in the final DRAIN cycle, before the bank toggles.
- i_start while busy is ignored. A start coincident with o_done is ignored (the FSM is in DONE, not IDLE).

Optional Feature:
SEQ_CYCLE_CNT_EN.
- Defined: o_cycle_count clears on start acceptance, increments every cycle while o_busy, saturates at 16'hFFFF, and holds its value after o_done until the next start.
- Undefined: o_cycle_count is tied to 0 and no counter flops exist.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum seq_state_t (IDLE, ISSUE, DRAIN, DONE);
  - the function stages_to_points(log2n);
  - a localparam for the o_cycle_count width.
- Sub-module fft_delay_line (parameters WIDTH, DEPTH; async-reset shift register) is used for the wb_valid/wb_idx pipe.

Test Plan:
- MAX_LOG2N=10, LANES=4, PIPE_DELAY=5, i_log2n=3, pulse start -> 3 stages of 1 issue + 5 drain cycles each; o_done 18 cycles after o_busy rises; o_stride 4,2,1; o_bank_sel 0,1,0.
- i_log2n=10 -> 128 issue cycles per stage, o_calc_idx 0,4,...,508, 10 stages, o_done after 1330 cycles; o_group_count 1..512.
- Toggle i_stall in stage 0 with i_log2n=4 -> o_calc_idx sequence 0,4 unchanged; each stall cycle extends the run by 1 cycle; o_wb_idx matches o_calc_idx 5 cycles later.
- i_log2n=1 and i_log2n=11 -> one-cycle o_cfg_err each, o_busy stays 0; i_start during a run -> no effect.
- Deassert i_resetn at stage 2 of a 1024-point run -> all outputs 0 immediately; a new start then completes normally.
- With SEQ_CYCLE_CNT_EN, i_log2n=3 -> o_cycle_count reads 18 after o_done; without the macro -> it reads 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
package fft_pkg;

  localparam int CYCLE_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

  function automatic int unsigned stages_to_points(input int unsigned log2n);
    return 32'd1 << log2n;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with async active-low clear.
module fft_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage/address sequencer: issues LANES butterflies per cycle over all stages.
// Optional cycle counter on o_cycle_count enabled by defining SEQ_CYCLE_CNT_EN.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int MAX_LOG2N  = 10,
  parameter int LANES      = 4,
  parameter int PIPE_DELAY = 5
) (
  input  logic                           clk,
  input  logic                           i_resetn,
  input  logic                           i_start,
  input  logic [$clog2(MAX_LOG2N+1)-1:0] i_log2n,
  input  logic                           i_stall,
  output logic                           o_busy,
  output logic                           o_cfg_err,
  output logic                           o_stage_start,
  output logic [$clog2(MAX_LOG2N)-1:0]   o_stage_idx,
  output logic                           o_issue_valid,
  output logic [MAX_LOG2N-2:0]           o_calc_idx,
  output logic [MAX_LOG2N-1:0]           o_stride,
  output logic [MAX_LOG2N-1:0]           o_stride_idx_offset,
  output logic [MAX_LOG2N-1:0]           o_group_count,
  output logic                           o_bank_sel,
  output logic                           o_wb_valid,
  output logic [MAX_LOG2N-2:0]           o_wb_idx,
  output logic                           o_done,
  output logic [CYCLE_CNT_W-1:0]         o_cycle_count
);

  localparam int LW         = $clog2(MAX_LOG2N+1);
  localparam int SW         = $clog2(MAX_LOG2N);
  localparam int DW         = $clog2(PIPE_DELAY+1);
  localparam int IW         = MAX_LOG2N-1;
  localparam int LOG2_LANES = $clog2(LANES);

  seq_state_t           state;
  logic [LW-1:0]        log2n_r;
  logic [SW-1:0]        stage;
  logic [MAX_LOG2N-1:0] cnt;
  logic [DW-1:0]        drain_cnt;
  logic                 bank;
  logic                 first;
  logic                 cfg_err_r;

  logic                 cfg_ok, active, last_issue, last_stage, drain_end;
  logic [MAX_LOG2N-1:0] half;
  logic [MAX_LOG2N:0]   next_cnt;

  assign cfg_ok     = (32'(i_log2n) >= 32'd2) && (32'(i_log2n) <= 32'(MAX_LOG2N));
  assign active     = (state == ISSUE) || (state == DRAIN);
  assign half       = MAX_LOG2N'(stages_to_points(32'(log2n_r)) >> 1);
  // One extra bit so counter+LANES can be compared against N/2 without wrapping.
  assign next_cnt   = {1'b0, cnt} + (MAX_LOG2N+1)'(LANES);
  assign last_issue = next_cnt >= {1'b0, half};
  assign last_stage = stage == SW'(log2n_r - 1'b1);
  assign drain_end  = drain_cnt == DW'(PIPE_DELAY-1);

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state     <= IDLE;
      log2n_r   <= '0;
      stage     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      bank      <= 1'b0;
      first     <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (cfg_ok) begin
              log2n_r <= i_log2n;
              stage   <= '0;
              cnt     <= '0;
              bank    <= 1'b0;
              first   <= 1'b1;
              state   <= ISSUE;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Stage-start marks only the first ISSUE cycle, stalled or not.
          first <= 1'b0;
          if (!i_stall) begin
            cnt <= next_cnt[MAX_LOG2N-1:0];
            if (last_issue) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            if (last_stage) begin
              state <= DONE;
            end else begin
              stage <= stage + 1'b1;
              cnt   <= '0;
              bank  <= ~bank;
              first <= 1'b1;
              state <= ISSUE;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy              = active;
  assign o_cfg_err           = cfg_err_r;
  assign o_stage_start       = (state == ISSUE) && first;
  assign o_stage_idx         = stage;
  assign o_issue_valid       = (state == ISSUE) && !i_stall;
  assign o_calc_idx          = cnt[IW-1:0];
  assign o_stride            = active ? (half >> stage) : '0;
  assign o_stride_idx_offset = o_stride >> LOG2_LANES;
  assign o_group_count       = active ? (MAX_LOG2N'(1) << stage) : '0;
  assign o_bank_sel          = bank;
  assign o_done              = (state == DONE);

  fft_delay_line #(
    .WIDTH(MAX_LOG2N),
    .DEPTH(PIPE_DELAY)
  ) u_wb_pipe (
    .clk   (clk),
    .resetn(i_resetn),
    .d     ({o_issue_valid, o_calc_idx}),
    .q     ({o_wb_valid, o_wb_idx})
  );

`ifdef SEQ_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cyc_cnt;

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn)                                cyc_cnt <= '0;
    else if (state == IDLE && i_start && cfg_ok)  cyc_cnt <= '0;
    else if (active && cyc_cnt != '1)             cyc_cnt <= cyc_cnt + 1'b1;
  end

  assign o_cycle_count = cyc_cnt;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: a run-level reference model fills queues, a monitor drains them.
module tb_fft_stage_sequencer;

  localparam int MAXL  = 10;
  localparam int LANES = 4;
  localparam int PD    = 5;
  localparam int LW    = $clog2(MAXL+1);
  localparam int SW    = $clog2(MAXL);

  logic            clk, i_resetn, i_start, i_stall;
  logic [LW-1:0]   i_log2n;
  logic            o_busy, o_cfg_err, o_stage_start, o_issue_valid, o_bank_sel, o_wb_valid, o_done;
  logic [SW-1:0]   o_stage_idx;
  logic [MAXL-2:0] o_calc_idx, o_wb_idx;
  logic [MAXL-1:0] o_stride, o_stride_idx_offset, o_group_count;
  logic [15:0]     o_cycle_count;

  fft_stage_sequencer #(.MAX_LOG2N(MAXL), .LANES(LANES), .PIPE_DELAY(PD)) dut (
    .clk(clk), .i_resetn(i_resetn), .i_start(i_start), .i_log2n(i_log2n), .i_stall(i_stall),
    .o_busy(o_busy), .o_cfg_err(o_cfg_err), .o_stage_start(o_stage_start),
    .o_stage_idx(o_stage_idx), .o_issue_valid(o_issue_valid), .o_calc_idx(o_calc_idx),
    .o_stride(o_stride), .o_stride_idx_offset(o_stride_idx_offset),
    .o_group_count(o_group_count), .o_bank_sel(o_bank_sel), .o_wb_valid(o_wb_valid),
    .o_wb_idx(o_wb_idx), .o_done(o_done), .o_cycle_count(o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int stage; int idx; int stride; int off; int gc; int bank; } iss_t;
  typedef struct { int l; int base; } run_t;

  iss_t exp_iss[$];
  int   exp_wb[$];
  int   wb_time[$];
  run_t exp_run[$];
  int   exp_err;
  int   n_cmp, n_bad;
  bit   in_rst;
  int   cyc, done_cnt, last_cc;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every stage issues butterfly groups 0, LANES, ... below N/2, then drains PD cycles.
  task automatic push_run(input int l);
    int n, half, per, stride;
    n    = 1 << l;
    half = n / 2;
    per  = (half / LANES > 0) ? half / LANES : 1;
    for (int s = 0; s < l; s++) begin
      stride = n >> (s + 1);
      for (int k = 0; k < half; k += LANES) begin
        exp_iss.push_back('{s, k, stride, stride / LANES, 1 << s, s % 2});
        exp_wb.push_back(k);
      end
    end
    exp_run.push_back('{l, l * (per + PD)});
  endtask

  always @(posedge clk) cyc++;

  initial begin : monitor
    bit   act, prev_busy;
    run_t cur;
    int   rise, issued, starts, stalls, per, lat, cc;
    iss_t e;
    act = 0; prev_busy = 0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        act = 0; prev_busy = 0;
      end else begin
        if (o_busy && !prev_busy) begin
          if (exp_run.size() == 0) chk("unexpected_start", 1, 0);
          else begin
            cur = exp_run.pop_front();
            act = 1; rise = cyc; issued = 0; starts = 0; stalls = 0;
            per = ((1 << cur.l) / 2 / LANES > 0) ? (1 << cur.l) / 2 / LANES : 1;
          end
        end
        if (act && o_busy && i_stall && issued < (int'(o_stage_idx) + 1) * per) stalls++;
        if (o_stage_start) starts++;
        if (o_issue_valid) begin
          if (exp_iss.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            e = exp_iss.pop_front();
            chk("calc_idx", o_calc_idx, e.idx);
            chk("stage_idx", o_stage_idx, e.stage);
            chk("stride", o_stride, e.stride);
            chk("stride_off", o_stride_idx_offset, e.off);
            chk("group_count", o_group_count, e.gc);
            chk("bank_sel", o_bank_sel, e.bank);
          end
          issued++;
          wb_time.push_back(cyc + PD);
        end
        if (o_wb_valid) begin
          if (exp_wb.size() == 0) chk("unexpected_wb", 1, 0);
          else chk("wb_idx", o_wb_idx, exp_wb.pop_front());
          if (wb_time.size() == 0) chk("unexpected_wb_time", 1, 0);
          else chk("wb_time", cyc, wb_time.pop_front());
        end
        if (o_done) begin
          if (!act) chk("unexpected_done", 1, 0);
          else begin
            lat = cyc - rise;
            chk("done_latency", lat, cur.base + stalls);
            chk("stage_starts", starts, cur.l);
            chk("busy_at_done", o_busy, 0);
`ifdef SEQ_CYCLE_CNT_EN
            cc = (cur.base + stalls > 65535) ? 65535 : cur.base + stalls;
`else
            cc = 0;
`endif
            last_cc = cc;
            chk("cycle_count", o_cycle_count, cc);
            act = 0;
          end
          done_cnt++;
        end
        if (o_cfg_err) begin
          chk("cfg_err_expected", exp_err > 0, 1);
          if (exp_err > 0) exp_err--;
          chk("busy_on_cfg_err", o_busy, 0);
        end
        prev_busy = o_busy;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_cfg_err"}, o_cfg_err, 0);
    chk({tag, "_stage_start"}, o_stage_start, 0);
    chk({tag, "_stage_idx"}, o_stage_idx, 0);
    chk({tag, "_issue_valid"}, o_issue_valid, 0);
    chk({tag, "_calc_idx"}, o_calc_idx, 0);
    chk({tag, "_stride"}, o_stride, 0);
    chk({tag, "_stride_off"}, o_stride_idx_offset, 0);
    chk({tag, "_group_count"}, o_group_count, 0);
    chk({tag, "_bank_sel"}, o_bank_sel, 0);
    chk({tag, "_wb_valid"}, o_wb_valid, 0);
    chk({tag, "_wb_idx"}, o_wb_idx, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_cycle_count"}, o_cycle_count, 0);
  endtask

  task automatic flush();
    exp_iss.delete(); exp_wb.delete(); wb_time.delete(); exp_run.delete(); exp_err = 0;
  endtask

  task automatic do_reset();
    in_rst = 1; i_resetn = 0; i_start = 0; i_stall = 0;
    #1;
    check_zero("reset");
    flush();
    repeat (3) @(posedge clk);
    #1 i_resetn = 1;
    in_rst = 0;
  endtask

  // Junk starts (random log2n) land anywhere inside the run, including the DONE cycle.
  task automatic run(input int l, input bit stall_en, input bit junk);
    int target;
    @(posedge clk); #1;
    i_log2n = LW'(l); i_start = 1;
    push_run(l);
    target = done_cnt + 1;
    @(posedge clk); #1;
    i_start = 0;
    for (int n = 0; n < 6000; n++) begin
      if (done_cnt >= target) break;
      i_stall = stall_en && ($urandom % 3 == 0);
      if (junk && ($urandom % 8 == 0)) begin
        i_start = 1; i_log2n = LW'($urandom_range(0, 15));
      end else i_start = 0;
      @(posedge clk); #1;
    end
    i_start = 0; i_stall = 0;
    if (done_cnt < target) begin
      chk("run_timeout", 0, 1);
      do_reset();
    end else begin
      repeat (2) @(posedge clk); #1;
      chk("cycle_count_hold", o_cycle_count, last_cc);
      chk("idle_busy", o_busy, 0);
    end
  endtask

  task automatic bad_start(input int l);
    @(posedge clk); #1;
    i_log2n = LW'(l); i_start = 1; exp_err++;
    @(posedge clk); #1;
    i_start = 0;
    repeat (3) @(posedge clk); #1;
    chk("busy_after_bad", o_busy, 0);
    chk("cfg_err_consumed", exp_err, 0);
  endtask

  initial begin : driver
    bit hit;
    n_cmp = 0; n_bad = 0; exp_err = 0; done_cnt = 0; cyc = 0; last_cc = 0;
    i_log2n = '0;
    do_reset();

    run(3, 0, 0);
    run(10, 0, 0);
    run(4, 1, 0);
    bad_start(1);
    bad_start(11);
    bad_start(0);
    for (int r = 0; r < 5; r++) run($urandom_range(2, 7), 1'($urandom % 2), 1);
    run(2, 0, 1);

    // Abort a 1024-point run partway through stage 2.
    @(posedge clk); #1;
    i_log2n = LW'(10); i_start = 1;
    push_run(10);
    @(posedge clk); #1;
    i_start = 0;
    hit = 0;
    for (int n = 0; n < 2000; n++) begin
      if (o_stage_idx == 2 && o_busy) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    chk("reached_stage2", hit, 1);
    repeat (7) @(posedge clk); #1;
    do_reset();

    run(3, 0, 0);
    run(5, 1, 1);

    repeat (10) @(posedge clk); #1;
    chk("leftover_issue", exp_iss.size(), 0);
    chk("leftover_wb", exp_wb.size(), 0);
    chk("leftover_run", exp_run.size(), 0);
    chk("leftover_err", exp_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
